video_capture: RTL and testbench
================================

Name: video_capture

Overview:
- Simulation-side consumer sitting directly downstream of the laser500 core's video outputs in the verilator top.
- Samples hsync/vsync/display_enable and 6-bit RGB on each pixel-enable tick.
- Writes active pixels into a linear framebuffer port as packed 18-bit words and reports measured frame geometry.
- Emits a one-cycle pulse when each complete frame has been written, so the C++ harness knows when to blit.

Parameters:
MAX_W, 1024, framebuffer stride in pixels; must be a power of two
MAX_H, 512, maximum captured lines
ADDR_W, 19, framebuffer address width; must equal log2(MAX_W*MAX_H)
SYNC_POL, 0, sync active level (0 = active-low); applies to both hsync and vsync

Ports:
clk_48  in  1  system clock
reset  in  1  synchronous, active-low reset
ce_pix  in  1  pixel enable, one clk_48 cycle per pixel
hsync  in  1  core horizontal sync
vsync  in  1  core vertical sync
display_enable  in  1  active-video qualifier
r  in  6  red
g  in  6  green
b  in  6  blue
fb_we  out  1  framebuffer write strobe
fb_addr  out  ADDR_W  write address = y*MAX_W + x
fb_data  out  18  {r,g,b}
frame_done  out  1  one-cycle pulse at the end of each captured frame
frame_w  out  11  active width of the last completed frame
frame_h  out  10  active lines of the last completed frame
frame_count  out  16  completed frames, wraps at 0xFFFF->0
overflow  out  1  sticky flag; a pixel fell outside MAX_W x MAX_H

Behaviour:
- Reset (reset=0 at a clk_48 edge):
  - All outputs go to 0.
  - x and y counters go to 0.
  - State goes to SYNC_WAIT.
  - Takes effect mid-frame too; any partial frame is abandoned with no frame_done.
- Sampling:
  - All inputs are sampled only on cycles with ce_pix=1.
  - The previous sampled hsync, vsync and display_enable values are held to form edge detectors.
- Edge definitions:
  - Sync leading edge: the sampled level transitions from inactive to SYNC_POL.
  - de falling edge: display_enable goes 1->0 between consecutive ce_pix samples.
- State machine:
  - SYNC_WAIT: no writes. A vsync leading edge moves to CAPTURE and clears x, y and the line-width accumulator.
  - CAPTURE, active pixel (ce_pix=1 and display_enable=1):
    - If x<MAX_W and y<MAX_H: issue a write, then x++.
    - Otherwise: suppress the write, set overflow, and still increment x (saturating at 2047).
  - CAPTURE, de falling edge:
    - Capture the current x into line_w; x<=0; y++ (saturating at 1023).
    - A line is counted only if at least one active pixel preceded it.
  - CAPTURE, vsync leading edge:
    - frame_w <= max line_w seen in the frame.
    - frame_h <= y.
    - frame_done = 1 for exactly one clk_48 cycle.
    - frame_count++.
    - Clear x and y; remain in CAPTURE.
  - hsync edges do not advance y; y advances only on de falling edges. This tolerates cores whose hsync precedes blanking.
- Write timing:
  - fb_we, fb_addr and fb_data are registered.
  - fb_we is asserted on the clk_48 cycle after the sampling ce_pix cycle, for exactly one cycle.
  - fb_data and fb_addr are valid while fb_we=1 and hold their values otherwise.
  - fb_addr is formed as the concatenation {y, x[log2 MAX_W-1:0]}; no multiplier.
- Simultaneous events on the same ce_pix:
  - de falling edge together with vsync leading edge: the line is closed first (line_w and y updated), then the frame is closed. frame_h therefore includes that line.
  - Active pixel together with vsync leading edge: the pixel is written to the old frame at the pre-clear address, then counters clear.
- Zero-line frame (vsync leading edge with y=0): frame_done still pulses, with frame_h=0 and frame_w=0.
- ce_pix low: no state change except the fb_we deassert.
- overflow clears only on reset.

Decomposition:
- Shared package video_capture_pkg:
  - rgb18_t packed struct {r,g,b} of 6 bits each.
  - State enum cap_state_t {SYNC_WAIT, CAPTURE}.
  - Constants for the frame_w and frame_h widths.
- One sub-module, sync_edge: per-signal registered previous value plus polarity-aware leading/trailing edge outputs, advanced by ce_pix. Instantiated three times (hsync, vsync, display_enable).

Test Plan:
- Reset held, then released with no vsync and 500 active pixels -> fb_we never asserts; state stays SYNC_WAIT; frame_count=0.
- Vsync, then 2 frames of 720 pixels x 192 lines, SYNC_POL=0 -> exactly 720*192 writes per frame; first write addr=0; last write addr=191*1024+719=196303; frame_w=720, frame_h=192, frame_count=2, two single-cycle frame_done pulses.
- Pixel r=0x3F, g=0x00, b=0x15 at x=3, y=2 -> fb_we one cycle after the ce_pix sample; fb_addr=2051; fb_data=0x3F015.
- Line of 1030 active pixels -> 1024 writes, 6 suppressed, overflow=1 and remaining 1 after subsequent clean frames; frame_w=1030.
- de falling edge and vsync leading edge on the same ce_pix after 100 lines -> frame_h=101; next frame starts at addr 0.
- reset low for one cycle mid-frame at y=50 -> all outputs 0 on the following cycle; no frame_done; capture resumes only after the next vsync leading edge.

Source files
------------

// File: rtl/video_capture_pkg.sv
// Shared types and constants for the video capture block.
package video_capture_pkg;

    localparam int FRAME_W_BITS = 11;
    localparam int FRAME_H_BITS = 10;

    // Counter ceilings: x and y stick here instead of wrapping.
    localparam logic [FRAME_W_BITS-1:0] X_SAT = '1;
    localparam logic [FRAME_H_BITS-1:0] Y_SAT = '1;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb18_t;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        CAPTURE   = 1'b1
    } cap_state_t;

endpackage

// File: rtl/video_capture_sync_edge.sv
// Edge detector for one video timing signal, advanced only on pixel ticks.
// POL is the level treated as "active"; lead fires on inactive->active,
// trail on active->inactive. No edge is reported until one sample has been
// taken after reset, so a signal already active at reset release is not
// mistaken for a fresh edge.
module sync_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk_48,
    input  logic reset,
    input  logic ce_pix,
    input  logic sig,
    output logic lead,
    output logic trail
);

    logic prev_d, prev_q;
    logic primed_d, primed_q;

    // Remember the previous sampled level on each pixel tick.
    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        if (ce_pix) begin
            prev_d   = sig;
            primed_d = 1'b1;
        end
    end

    // Sample history register with active-low synchronous reset.
    always_ff @(posedge clk_48) begin
        if (!reset) begin
            prev_q   <= ~POL;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
        end
    end

    assign lead  = ce_pix & primed_q & (sig == POL) & (prev_q != POL);
    assign trail = ce_pix & primed_q & (sig != POL) & (prev_q == POL);

endmodule

// File: rtl/video_capture.sv
// Captures active video into a linear framebuffer and measures frame size.
// Lines are delimited by display_enable falling edges (not hsync), frames by
// vsync leading edges. Writes and frame_done are registered, one cycle after
// the sampling pixel tick.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int   MAX_W    = 1024,
    parameter int   MAX_H    = 512,
    parameter int   ADDR_W   = 19,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                    clk_48,
    input  logic                    reset,
    input  logic                    ce_pix,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    display_enable,
    input  logic [5:0]              r,
    input  logic [5:0]              g,
    input  logic [5:0]              b,
    output logic                    fb_we,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [17:0]             fb_data,
    output logic                    frame_done,
    output logic [FRAME_W_BITS-1:0] frame_w,
    output logic [FRAME_H_BITS-1:0] frame_h,
    output logic [15:0]             frame_count,
    output logic                    overflow
);

    localparam int XW = $clog2(MAX_W);
    localparam int YW = $clog2(MAX_H);
    localparam logic [FRAME_W_BITS-1:0] X_LIMIT = FRAME_W_BITS'(MAX_W);
    localparam logic [FRAME_H_BITS-1:0] Y_LIMIT = FRAME_H_BITS'(MAX_H);

    logic hs_lead, hs_trail, vs_lead, vs_trail, de_lead, de_fall;

    sync_edge #(.POL(SYNC_POL)) u_hs_edge (
        .clk_48 (clk_48), .reset (reset), .ce_pix (ce_pix),
        .sig    (hsync),  .lead  (hs_lead), .trail (hs_trail)
    );

    sync_edge #(.POL(SYNC_POL)) u_vs_edge (
        .clk_48 (clk_48), .reset (reset), .ce_pix (ce_pix),
        .sig    (vsync),  .lead  (vs_lead), .trail (vs_trail)
    );

    sync_edge #(.POL(1'b1)) u_de_edge (
        .clk_48 (clk_48), .reset (reset), .ce_pix (ce_pix),
        .sig    (display_enable), .lead (de_lead), .trail (de_fall)
    );

    // hsync is tracked but deliberately never advances y: some cores raise
    // hsync before blanking, so line boundaries come from display_enable.
    logic unused_edges;
    assign unused_edges = hs_lead | hs_trail | vs_trail | de_lead;

    cap_state_t              state_d, state_q;
    logic [FRAME_W_BITS-1:0] x_d, x_q;
    logic [FRAME_H_BITS-1:0] y_d, y_q;
    logic [FRAME_W_BITS-1:0] line_max_d, line_max_q;
    logic                    fb_we_d, fb_we_q;
    logic [ADDR_W-1:0]       fb_addr_d, fb_addr_q;
    rgb18_t                  fb_data_d, fb_data_q;
    logic                    frame_done_d, frame_done_q;
    logic [FRAME_W_BITS-1:0] frame_w_d, frame_w_q;
    logic [FRAME_H_BITS-1:0] frame_h_d, frame_h_q;
    logic [15:0]             frame_count_d, frame_count_q;
    logic                    overflow_d, overflow_q;

    // Line/frame bookkeeping after a possible line close on this tick, so a
    // frame closed on the same tick includes that line.
    logic [FRAME_H_BITS-1:0] y_close;
    logic [FRAME_W_BITS-1:0] max_close;

    // Next-state: pixel write, line close, then frame close, in that order.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        line_max_d    = line_max_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        frame_done_d  = 1'b0;
        frame_w_d     = frame_w_q;
        frame_h_d     = frame_h_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        y_close       = y_q;
        max_close     = line_max_q;

        if (ce_pix) begin
            unique case (state_q)
                SYNC_WAIT: begin
                    if (vs_lead) begin
                        state_d    = CAPTURE;
                        x_d        = '0;
                        y_d        = '0;
                        line_max_d = '0;
                    end
                end
                CAPTURE: begin
                    if (display_enable) begin
                        if ((x_q < X_LIMIT) && (y_q < Y_LIMIT)) begin
                            fb_we_d   = 1'b1;
                            fb_addr_d = ADDR_W'({y_q[YW-1:0], x_q[XW-1:0]});
                            fb_data_d = '{r: r, g: g, b: b};
                        end else begin
                            overflow_d = 1'b1;
                        end
                        x_d = (x_q == X_SAT) ? x_q : x_q + 1'b1;
                    end

                    // A line only counts if some active pixel preceded it.
                    if (de_fall) begin
                        x_d = '0;
                        if (x_q != '0) begin
                            y_close = (y_q == Y_SAT) ? y_q : y_q + 1'b1;
                            if (x_q > line_max_q) begin
                                max_close = x_q;
                            end
                        end
                    end
                    y_d        = y_close;
                    line_max_d = max_close;

                    if (vs_lead) begin
                        frame_w_d     = max_close;
                        frame_h_d     = y_close;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        x_d           = '0;
                        y_d           = '0;
                        line_max_d    = '0;
                    end
                end
                default: state_d = SYNC_WAIT;
            endcase
        end
    end

    // State and output registers with active-low synchronous reset.
    always_ff @(posedge clk_48) begin
        if (!reset) begin
            state_q       <= SYNC_WAIT;
            x_q           <= '0;
            y_q           <= '0;
            line_max_q    <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_w_q     <= '0;
            frame_h_q     <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_max_q    <= line_max_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            frame_done_q  <= frame_done_d;
            frame_w_q     <= frame_w_d;
            frame_h_q     <= frame_h_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;
    assign frame_done  = frame_done_q;
    assign frame_w     = frame_w_q;
    assign frame_h     = frame_h_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_video_capture.sv
// Self-checking bench for video_capture: randomized lines/pixels against a
// frame-level reference model (expected write list plus expected geometry).
module tb_video_capture;

    logic        clk_48 = 1'b0;
    logic        reset = 1'b0;
    logic        ce_pix = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        display_enable = 1'b0;
    logic [5:0]  r = '0, g = '0, b = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [17:0] fb_data;
    logic        frame_done;
    logic [10:0] frame_w;
    logic [9:0]  frame_h;
    logic [15:0] frame_count;
    logic        overflow;

    video_capture dut (
        .clk_48 (clk_48), .reset (reset), .ce_pix (ce_pix),
        .hsync (hsync), .vsync (vsync), .display_enable (display_enable),
        .r (r), .g (g), .b (b),
        .fb_we (fb_we), .fb_addr (fb_addr), .fb_data (fb_data),
        .frame_done (frame_done), .frame_w (frame_w), .frame_h (frame_h),
        .frame_count (frame_count), .overflow (overflow)
    );

    always #5 clk_48 = ~clk_48;

    // Observed writes and frame_done high cycles.
    logic [36:0] act_q[$];
    int          done_cnt = 0;
    always @(negedge clk_48) begin
        if (fb_we === 1'b1) act_q.push_back({fb_addr, fb_data});
        if (frame_done === 1'b1) done_cnt++;
    end

    // Reference model: frame-level view of what the stimulus should produce.
    logic [36:0] exp_q[$];
    int act_ptr = 0, exp_ptr = 0;
    bit in_cap = 0;
    int m_x = 0, m_y = 0, m_maxw = 0, m_lines = 0, m_count = 0;
    bit m_ovf = 0;
    int exp_w = 0, exp_h = 0, exp_done = 0;
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        ce_pix = 1'b0;
        repeat (n) @(negedge clk_48);
    endtask

    // One pixel-tick sample, optionally followed by a gap cycle.
    task automatic smp(input logic h, input logic v, input logic de, input logic [17:0] px);
        hsync = h; vsync = v; display_enable = de; {r, g, b} = px; ce_pix = 1'b1;
        @(negedge clk_48);
        ce_pix = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk_48);
    endtask

    function automatic void model_px(input logic [17:0] px);
        if (in_cap) begin
            if (m_x < 1024 && m_y < 512) exp_q.push_back({19'(m_y * 1024 + m_x), px});
            else m_ovf = 1;
            m_x++;
        end
    endfunction

    function automatic void model_line_end();
        if (in_cap && m_x > 0) begin
            if (m_x > m_maxw) m_maxw = m_x;
            m_lines++;
            m_y++;
        end
        m_x = 0;
    endfunction

    function automatic void model_frame_end();
        if (in_cap) begin
            exp_w = m_maxw; exp_h = m_lines; m_count++; exp_done++;
        end
        in_cap = 1; m_x = 0; m_y = 0; m_maxw = 0; m_lines = 0;
    endfunction

    task automatic send_px(input logic [17:0] px);
        model_px(px);
        smp(1'b1, 1'b1, 1'b1, px);
    endtask

    task automatic line_head();
        smp(1'b0, 1'b1, 1'b0, '0);
        smp(1'b0, 1'b1, 1'b0, '0);
        smp(1'b1, 1'b1, 1'b0, '0);
    endtask

    // hsync pulse, w active pixels, blanking; merge puts the vsync leading
    // edge on the same tick as the display_enable falling edge.
    task automatic send_line(input int w, input bit merge);
        line_head();
        for (int i = 0; i < w; i++) send_px(18'($urandom));
        model_line_end();
        if (merge) model_frame_end();
        smp(1'b1, !merge, 1'b0, '0);
        smp(1'b1, !merge, 1'b0, '0);
    endtask

    task automatic vsync_pulse();
        model_frame_end();
        smp(1'b1, 1'b0, 1'b0, '0);
        smp(1'b1, 1'b0, 1'b0, '0);
        smp(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic check_writes(input string tag);
        int n_act, n_exp, n_bad;
        n_act = act_q.size() - act_ptr;
        n_exp = exp_q.size() - exp_ptr;
        n_bad = 0;
        check({tag, "_wr_count"}, n_act, n_exp);
        for (int i = 0; i < n_act && i < n_exp; i++)
            if (act_q[act_ptr + i] !== exp_q[exp_ptr + i]) n_bad++;
        check({tag, "_wr_bad"}, n_bad, 0);
        act_ptr = act_q.size();
        exp_ptr = exp_q.size();
    endtask

    task automatic check_frame(input string tag);
        idle(3);
        check({tag, "_frame_w"}, frame_w, exp_w);
        check({tag, "_frame_h"}, frame_h, exp_h);
        check({tag, "_frame_count"}, frame_count, m_count & 16'hFFFF);
        check({tag, "_done_cycles"}, done_cnt, exp_done);
        check({tag, "_overflow"}, overflow, m_ovf);
        check_writes(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_w"}, frame_w, 0);
        check({tag, "_frame_h"}, frame_h, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nl;
        // Reset state.
        repeat (3) @(negedge clk_48);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk_48);

        // No vsync yet: 500 active pixels must not be written.
        send_line(500, 1'b0);
        idle(3);
        check_writes("no_vsync");
        check("no_vsync_frame_count", frame_count, 0);

        // First vsync only arms capture; no frame_done.
        vsync_pulse();
        check_frame("arm");

        // Two randomized frames; the second includes a full-stride line.
        for (int f = 0; f < 2; f++) begin
            nl = $urandom_range(3, 6);
            for (int l = 0; l < nl; l++) send_line($urandom_range(0, 40), 1'b0);
            if (f == 1) send_line(1024, 1'b0);
            vsync_pulse();
            check_frame($sformatf("rand%0d", f));
        end

        // Directed pixel at x=3, y=2: write timing, address and data.
        send_line(4, 1'b0);
        send_line(4, 1'b0);
        line_head();
        for (int i = 0; i < 3; i++) send_px(18'($urandom));
        model_px(18'h3F015);
        hsync = 1'b1; vsync = 1'b1; display_enable = 1'b1;
        r = 6'h3F; g = 6'h00; b = 6'h15; ce_pix = 1'b1;
        @(posedge clk_48); #1;
        check("px_fb_we", fb_we, 1);
        check("px_fb_addr", fb_addr, 2051);
        check("px_fb_data", fb_data, 18'h3F015);
        @(negedge clk_48);
        ce_pix = 1'b0;
        @(posedge clk_48); #1;
        check("px_fb_we_drop", fb_we, 0);
        check("px_fb_addr_hold", fb_addr, 2051);
        @(negedge clk_48);
        model_line_end();
        smp(1'b1, 1'b1, 1'b0, '0);
        smp(1'b1, 1'b1, 1'b0, '0);
        vsync_pulse();
        check_frame("pixel");

        // de falling edge and vsync leading edge on the same tick.
        for (int l = 0; l < 100; l++) send_line($urandom_range(1, 8), 1'b0);
        send_line($urandom_range(1, 8), 1'b1);
        check_frame("merge");
        check("merge_h_101", frame_h, 101);
        send_line(5, 1'b0);
        idle(3);
        check("merge_next_addr0", (act_q.size() > act_ptr) ? act_q[act_ptr][36:18] : 19'h7FFFF, 0);
        vsync_pulse();
        check_frame("after_merge");

        // Over-wide line, then a clean frame and a zero-line frame.
        send_line(1030, 1'b0);
        send_line(3, 1'b0);
        vsync_pulse();
        check_frame("ovf");
        send_line(10, 1'b0);
        vsync_pulse();
        check_frame("ovf_sticky");
        vsync_pulse();
        check_frame("zero_lines");

        // Reset mid-frame at y=50: partial frame dropped.
        for (int l = 0; l < 50; l++) send_line($urandom_range(2, 6), 1'b0);
        line_head();
        for (int i = 0; i < 3; i++) send_px(18'($urandom));
        idle(3);
        check_writes("pre_reset");
        reset = 1'b0;
        @(negedge clk_48);
        reset = 1'b1;
        check_all_zero("mid_reset");
        in_cap = 0; m_count = 0; m_ovf = 0; exp_w = 0; exp_h = 0;
        m_x = 0; m_y = 0; m_maxw = 0; m_lines = 0;
        send_line(20, 1'b0);
        send_line(20, 1'b0);
        vsync_pulse();
        check_frame("post_reset_arm");
        send_line(7, 1'b0);
        vsync_pulse();
        check_frame("post_reset_frame");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
